// File: rtl/divider_controller.sv
// divider_controller: sequencing FSM for a restoring shift/subtract divider.
// Drives the A/Q/M datapath controls for one N-iteration division per start.
module divider_controller #(
    parameter int N     = 8,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic MSB_ASM,
    output logic plA,
    output logic shA,
    output logic initA,
    output logic plQ,
    output logic shQ,
    output logic siQ,
    output logic plM,
    output logic ready,
    output logic busy,
    output logic done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and iteration counter registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and counter: start is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = ITER;
            end
            ITER: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Datapath controls decoded from state; ITER picks subtract or shift.
    always_comb begin
        plA   = 1'b0;
        shA   = 1'b0;
        initA = 1'b0;
        plQ   = 1'b0;
        shQ   = 1'b0;
        siQ   = 1'b0;
        plM   = 1'b0;
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
            end
            LOAD: begin
                plQ   = 1'b1;
                plM   = 1'b1;
                initA = 1'b1;
                busy  = 1'b1;
            end
            ITER: begin
                busy = 1'b1;
                shQ  = 1'b1;
                // Negative trial result: keep A by plain shift, quotient bit 0.
                plA  = ~MSB_ASM;
                shA  = MSB_ASM;
                siQ  = ~MSB_ASM;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                ready = 1'b1;
            end
        endcase
    end

endmodule
